// File: rtl/mmio_peripherals_pkg.sv
// mmio_peripherals_pkg: register offsets and 7-segment decode shared by the MMIO block
package mmio_peripherals_pkg;
    localparam logic [4:0] LED_OFS    = 5'h00;
    localparam logic [4:0] SW_OFS     = 5'h04;
    localparam logic [4:0] BTN_OFS    = 5'h08;
    localparam logic [4:0] IPIN_OFS   = 5'h0C;
    localparam logic [4:0] OPIN_OFS   = 5'h10;
    localparam logic [4:0] HEXVAL_OFS = 5'h14;
    localparam logic [4:0] HEXDOT_OFS = 5'h18;
    localparam logic [4:0] CYCLES_OFS = 5'h1C;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction
endpackage

// File: rtl/mmio_peripherals_seven_seg_mux.sv
// seven_seg_mux: scans four active-low 7-segment digits from a 16-bit value
module seven_seg_mux
    import mmio_peripherals_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dots,
    output logic [6:0]  hex,
    output logic        hex_dot,
    output logic [3:0]  hex_sel
);
    localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    logic [PW-1:0] presc;
    logic [1:0]    idx;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end
    assign hex     = seg_decode(value[{idx, 2'b00} +: 4]);
    assign hex_dot = ~dots[idx];
    assign hex_sel = ~(4'b0001 << idx);
endmodule

// File: rtl/mmio_peripherals.sv
// mmio_peripherals: LED/pin/display registers, synchronised inputs and cycle counter
module mmio_peripherals
    import mmio_peripherals_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  A,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    input  logic [15:0] sw,
    input  logic [4:0]  btn,
    input  logic [3:0]  ipin,
    output logic [15:0] led,
    output logic [3:0]  opin,
    output logic [6:0]  hex,
    output logic        hex_dot,
    output logic [3:0]  hex_sel
);
    logic [15:0] hexval, sw_s1, sw_s2;
    logic [3:0]  hexdot, ipin_s1, ipin_s2;
    logic [4:0]  btn_s1, btn_s2;
    logic [31:0] cycles;
    logic [4:0]  ofs;
    logic        unused_bits;
    assign ofs = {A[4:2], 2'b00};
    assign unused_bits = ^{WD[31:16], A[1:0]};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led     <= '0;
            opin    <= '0;
            hexval  <= '0;
            hexdot  <= '0;
            cycles  <= '0;
            {sw_s1, sw_s2, btn_s1, btn_s2, ipin_s1, ipin_s2} <= '0;
        end else begin
            cycles  <= cycles + 32'd1;
            sw_s1   <= sw;
            sw_s2   <= sw_s1;
            btn_s1  <= btn;
            btn_s2  <= btn_s1;
            ipin_s1 <= ipin;
            ipin_s2 <= ipin_s1;
            if (WE && ofs == LED_OFS)    led    <= WD[15:0];
            if (WE && ofs == OPIN_OFS)   opin   <= WD[3:0];
            if (WE && ofs == HEXVAL_OFS) hexval <= WD[15:0];
            if (WE && ofs == HEXDOT_OFS) hexdot <= WD[3:0];
        end
    end
    always_comb begin
        RD = '0;
        case (ofs)
            LED_OFS:    RD = {16'h0, led};
            SW_OFS:     RD = {16'h0, sw_s2};
            BTN_OFS:    RD = {27'h0, btn_s2};
            IPIN_OFS:   RD = {28'h0, ipin_s2};
            OPIN_OFS:   RD = {28'h0, opin};
            HEXVAL_OFS: RD = {16'h0, hexval};
            HEXDOT_OFS: RD = {28'h0, hexdot};
            default:    RD = cycles;
        endcase
    end
    seven_seg_mux #(.REFRESH_DIV(REFRESH_DIV)) u_seg (
        .clk(clk), .rst_n(rst_n), .value(hexval), .dots(hexdot),
        .hex(hex), .hex_dot(hex_dot), .hex_sel(hex_sel)
    );
endmodule

// File: tb/tb_mmio_peripherals.sv
// tb_mmio_peripherals: directed and random checks against a register-map reference model
module tb_mmio_peripherals;
    localparam int DIV = 4;
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    logic clk = 0;
    logic rst_n, WE, hex_dot;
    logic [4:0] A, btn;
    logic [31:0] WD, RD;
    logic [15:0] sw, led;
    logic [3:0] ipin, opin, hex_sel;
    logic [6:0] hex;
    int total = 0, bad = 0;
    logic [15:0] m_led, m_hexval;
    logic [3:0] m_opin, m_hexdot;
    logic [31:0] m_cyc;
    int t;
    logic [15:0] sw_q[$];
    logic [4:0] btn_q[$];
    logic [3:0] ipin_q[$];

    always #10 clk = ~clk;

    mmio_peripherals #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .WD(WD), .WE(WE), .RD(RD),
        .sw(sw), .btn(btn), .ipin(ipin), .led(led), .opin(opin),
        .hex(hex), .hex_dot(hex_dot), .hex_sel(hex_sel));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int w);
        case (w)
            0: return {16'h0, m_led};
            1: return {16'h0, sw_q[sw_q.size()-2]};
            2: return {27'h0, btn_q[btn_q.size()-2]};
            3: return {28'h0, ipin_q[ipin_q.size()-2]};
            4: return {28'h0, m_opin};
            5: return {16'h0, m_hexval};
            6: return {28'h0, m_hexdot};
            default: return m_cyc;
        endcase
    endfunction

    // Apply the edge to the model using the inputs held across it, then advance the clock.
    task automatic tick();
        if (!rst_n) begin
            {m_led, m_hexval, m_opin, m_hexdot, m_cyc} = '0;
            t = 0;
            sw_q = '{16'h0, 16'h0};
            btn_q = '{5'h0, 5'h0};
            ipin_q = '{4'h0, 4'h0};
        end else begin
            if (WE)
                case (A[4:2])
                    3'd0: m_led = WD[15:0];
                    3'd4: m_opin = WD[3:0];
                    3'd5: m_hexval = WD[15:0];
                    3'd6: m_hexdot = WD[3:0];
                    default: ;
                endcase
            m_cyc++;
            t++;
            sw_q.push_back(sw);
            btn_q.push_back(btn);
            ipin_q.push_back(ipin);
            void'(sw_q.pop_front());
            void'(btn_q.pop_front());
            void'(ipin_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [4:0] a;
        int d;
        a = A;
        for (int w = 0; w < 8; w++) begin
            A = {w[2:0], 2'b00};
            #1;
            chk($sformatf("%s_rd%0d", tag, w), RD, m_read(w));
        end
        A = a;
        d = (t / DIV) % 4;
        chk({tag, "_led"}, {16'h0, led}, {16'h0, m_led});
        chk({tag, "_opin"}, {28'h0, opin}, {28'h0, m_opin});
        chk({tag, "_sel"}, {28'h0, hex_sel}, {28'h0, ~(4'b0001 << d)});
        chk({tag, "_hex"}, {25'h0, hex}, {25'h0, SEG[m_hexval[d*4 +: 4]]});
        chk({tag, "_dot"}, {31'h0, hex_dot}, {31'h0, ~m_hexdot[d]});
    endtask

    initial begin
        rst_n = 0; WE = 0; A = 0; WD = 0; sw = 0; btn = 0; ipin = 0;
        tick();
        tick();
        rst_n = 1;
        chk("rst_sel", {28'h0, hex_sel}, 32'hE);
        chk("rst_hex", {25'h0, hex}, 32'h40);
        chk("rst_dot", {31'h0, hex_dot}, 32'h1);
        check_all("reset");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("count");
        end
        A = 5'h1C; #1;
        chk("cycles3", RD, 32'd3);
        WE = 1; A = 5'h00; WD = 32'hFFFF_A5A5;
        tick();
        WE = 0;
        chk("led_a5a5", {16'h0, led}, 32'h0000_A5A5);
        check_all("wr_led");
        WE = 1; A = 5'h10; WD = 32'hF3;
        tick();
        chk("opin3", {28'h0, opin}, 32'h3);
        A = 5'h04; WD = 32'h1234;
        tick();
        WE = 0;
        check_all("wr_ro");
        sw = 16'hBEEF; btn = 5'b10001; ipin = 4'h9;
        tick();
        check_all("sync1");
        tick();
        A = 5'h04; #1; chk("sw_sync", RD, 32'hBEEF);
        A = 5'h08; #1; chk("btn_sync", RD, 32'h11);
        A = 5'h0C; #1; chk("ipin_sync", RD, 32'h9);
        check_all("sync2");
        WE = 1; A = 5'b00011; WD = 32'h5A5A;
        tick();
        WE = 0;
        chk("led_a11", {16'h0, led}, 32'h5A5A);
        rst_n = 0;
        tick();
        rst_n = 1;
        WE = 1; A = 5'h14; WD = 32'h8F21;
        tick();
        A = 5'h18; WD = 32'h4;
        tick();
        WE = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all("scan");
        end
        for (int i = 0; i < 16 && (t / DIV) % 4 != 2; i++) tick();
        chk("scan_d2_sel", {28'h0, hex_sel}, 32'hB);
        chk("scan_d2_hex", {25'h0, hex}, 32'h0E);
        chk("scan_d2_dot", {31'h0, hex_dot}, 32'h0);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("midrst_sel", {28'h0, hex_sel}, 32'hE);
        chk("midrst_led", {16'h0, led}, 32'h0);
        check_all("midrst");
        A = 5'h1C;
        force dut.cycles = 32'hFFFF_FFFF;
        #1;
        release dut.cycles;
        m_cyc = 32'hFFFF_FFFF;
        #1;
        chk("cyc_max", RD, 32'hFFFF_FFFF);
        tick();
        chk("cyc_wrap", RD, 32'h0);
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            WE = 1'($urandom_range(0, 1));
            A = 5'($urandom);
            WD = $urandom;
            sw = 16'($urandom);
            btn = 5'($urandom);
            ipin = 4'($urandom);
            tick();
            check_all("rand");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mmio_peripherals.md
Name: mmio_peripherals

Overview:
Memory-mapped I/O block for the multi-cycle RISC-V microcontroller, selected by the memory module for byte addresses ≥ 0x700 and addressed by a 5-bit byte offset.
- Holds the LED, output-pin and 7-segment display registers.
- Synchronises switches, buttons and input pins.
- Provides a free-running cycle counter.
- Drives a 4-digit multiplexed active-low 7-segment display.

Parameters:
REFRESH_DIV, 100000, clock cycles each display digit stays selected before the scan advances (must be ≥ 1).

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
A  in  5  byte offset within the peripheral window; A[1:0] ignored (word access)
WD  in  32  write data
WE  in  1  write enable, already qualified by the peripheral-window select
RD  out  32  read data, combinational from A and register state
sw  in  16  slide switches, asynchronous
btn  in  5  push buttons, asynchronous
ipin  in  4  general input pins, asynchronous
led  out  16  LED register
opin  out  4  output-pin register
hex  out  7  segments {g,f,e,d,c,b,a}, active-low
hex_dot  out  1  decimal point of the selected digit, active-low
hex_sel  out  4  digit anodes, active-low one-hot, bit 0 = rightmost digit

Behaviour:
Register map (offset A[4:2]; reads zero-extended to 32 bits):
- 0x00 LED, RW, 16 bits; drives led.
- 0x04 SW, RO; synchronised sw.
- 0x08 BTN, RO; synchronised btn.
- 0x0C IPIN, RO; synchronised ipin.
- 0x10 OPIN, RW, 4 bits; drives opin.
- 0x14 HEXVAL, RW, 16 bits; nibble k shown on digit k.
- 0x18 HEXDOT, RW, 4 bits; bit k = 1 lights the dot of digit k.
- 0x1C CYCLES, RO, 32-bit counter; +1 every cycle, wraps 0xFFFFFFFF→0.

Writes:
- On the rising edge with WE=1, write the addressed RW register from the low bits of WD; upper WD bits are discarded.
- Writes to RO offsets are ignored.
- A write is visible on led/opin and on RD from the cycle after the edge.
- Reading the address being written in the same cycle returns the old value.

Reads: RD is purely combinational with no extra latency.

Inputs: each of sw, btn and ipin passes through a 2-flop synchroniser. An input change is readable on RD after 2 rising edges.

Reset (rst_n=0 at an edge) clears:
- LED, OPIN, HEXVAL, HEXDOT, CYCLES and synchroniser flops to 0.
- The scan prescaler to 0 and the digit index to 0.

Post-reset outputs: led=0, opin=0, hex_sel=4'b1110, hex=7'b1000000 (digit "0"), hex_dot=1. Reset asserted mid-scan overrides everything in that cycle.

Display scan:
- The prescaler counts 0..REFRESH_DIV-1. On reaching REFRESH_DIV-1 it returns to 0 and the digit index advances 0→1→2→3→0.
- hex_sel = ~(1<<index).
- hex = decode(HEXVAL nibble[index]); hex_dot = ~HEXDOT[index].
- Decode table, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Outputs come from registered index/value, so changing HEXVAL takes effect on the next cycle.

Decomposition:
- Shared package: offset constants (LED_OFS, SW_OFS, BTN_OFS, IPIN_OFS, OPIN_OFS, HEXVAL_OFS, HEXDOT_OFS, CYCLES_OFS) and the 16-entry segment decode function.
- One sub-module, seven_seg_mux, holds the prescaler, digit index, decoder and anode/dot drive. Inputs: clk, rst_n, value[15:0], dots[3:0]; outputs: hex, hex_dot, hex_sel.

Test Plan:
- Reset: hold rst_n=0 two cycles, release → led=0, opin=0, hex_sel=1110, hex=1000000, hex_dot=1; RD at 0x1C counts 0,1,2,… per cycle.
- Write/read: WE=1, A=0x00, WD=0xFFFF_A5A5 → led=0xA5A5 next cycle, RD=0x0000A5A5. A=0x10, WD=0xF3 → opin=0x3. Write 0x1234 to A=0x04 → SW read unchanged.
- Inputs: sw=0xBEEF, btn=5'b10001, ipin=0x9 → RD at 0x04/0x08/0x0C is 0 after one edge, then 0xBEEF/0x11/0x9 after the second edge.
- Scan (REFRESH_DIV=4): HEXVAL=0x8F21, HEXDOT=0x4 → every 4 cycles (hex_sel, hex, hex_dot) steps through:
  - (1110, 1111001, 1)
  - (1101, 0100100, 1)
  - (1011, 0001110, 0)
  - (0111, 0000000, 1)
  - then wraps to digit 0.
- Edge cases: A[1:0]=2'b11 on a write to 0x00 still writes LED. Assert reset mid-scan at digit 2 → next cycle hex_sel=1110 and LED=0.
- Counter wrap: force the CYCLES count to 0xFFFFFFFF via a test hook or a long run → next read returns 0.
